// File: rtl/freq_ramp_ctrl_if.sv
// Signal bundle between a ramp requester and freq_ramp_ctrl.
// The requester drives config and pulses; the controller drives the generator word and status.
interface freq_ramp_ctrl_if #(
  parameter int PW = 32,
  parameter int DW = 16
);
  // Handshake: start/stop are one-cycle request pulses sampled on the rising clock
  // edge. There is no ready; a request the FSM cannot act on in its current state is
  // dropped, never queued. The config words only matter on the edge that takes start.
  logic          start;
  logic          stop;
  logic [PW-1:0] start_period;
  logic [PW-1:0] target_period;
  logic [PW-1:0] step;
  logic [DW-1:0] dwell;

  logic [PW-1:0] period_out;
  logic          gen_enable;
  logic          busy;
  logic          at_speed;
  logic          done;
  logic [1:0]    state;

  modport master (
    output start, stop, start_period, target_period, step, dwell,
    input  period_out, gen_enable, busy, at_speed, done, state
  );

  modport slave (
    input  start, stop, start_period, target_period, step, dwell,
    output period_out, gen_enable, busy, at_speed, done, state
  );
endinterface

// File: rtl/freq_ramp_ctrl.sv
// Trapezoidal half-period ramp controller: accelerates from start_period to target_period,
// holds at speed, then decelerates back and releases the frequency generator.
module freq_ramp_ctrl #(
  parameter int PW = 32,
  parameter int DW = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  freq_ramp_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    RUN   = 2'd2,
    DECEL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cfg_start_q, cfg_start_d;
  logic [PW-1:0] cfg_target_q, cfg_target_d;
  logic [PW-1:0] cfg_step_q, cfg_step_d;
  logic [DW-1:0] cfg_dwell_q, cfg_dwell_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          gen_q, gen_d;
  logic          busy_q, busy_d;
  logic          at_speed_q, at_speed_d;
  logic          done_q, done_d;

  logic [PW:0]   dec_sum;
  logic [PW:0]   inc_sum;
  logic [PW-1:0] dec_next;
  logic [PW-1:0] inc_next;
  logic          step_now;

  // One extra bit catches borrow/carry so period_out clamps instead of wrapping.
  always_comb begin
    dec_sum  = {1'b0, period_q} - {1'b0, cfg_step_q};
    inc_sum  = {1'b0, period_q} + {1'b0, cfg_step_q};
    dec_next = dec_sum[PW-1:0];
    inc_next = inc_sum[PW-1:0];
    if (dec_sum[PW] || (dec_sum[PW-1:0] < cfg_target_q)) begin
      dec_next = cfg_target_q;
    end
    if (inc_sum[PW] || (inc_sum[PW-1:0] > cfg_start_q)) begin
      inc_next = cfg_start_q;
    end
    step_now = (cnt_q == cfg_dwell_q);
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cfg_start_d  = cfg_start_q;
    cfg_target_d = cfg_target_q;
    cfg_step_d   = cfg_step_q;
    cfg_dwell_d  = cfg_dwell_q;
    cnt_d        = cnt_q;
    gen_d        = gen_q;
    busy_d       = busy_q;
    at_speed_d   = at_speed_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // start has priority over stop here; a lone stop is meaningless while idle.
        if (bus.start) begin
          cfg_start_d  = bus.start_period;
          cfg_target_d = bus.target_period;
          cfg_step_d   = (bus.step == '0) ? PW'(1) : bus.step;
          cfg_dwell_d  = bus.dwell;
          cnt_d        = '0;
          gen_d        = 1'b1;
          busy_d       = 1'b1;
          if (bus.target_period < bus.start_period) begin
            state_d    = ACCEL;
            period_d   = bus.start_period;
            at_speed_d = 1'b0;
          end else begin
            state_d    = RUN;
            period_d   = bus.target_period;
            at_speed_d = 1'b1;
          end
        end
      end

      ACCEL: begin
        if (bus.stop) begin
          state_d    = DECEL;
          cnt_d      = '0;
          at_speed_d = 1'b0;
        end else if (step_now) begin
          cnt_d    = '0;
          period_d = dec_next;
          if (dec_next == cfg_target_q) begin
            state_d    = RUN;
            at_speed_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d    = DECEL;
          cnt_d      = '0;
          at_speed_d = 1'b0;
        end
      end

      DECEL: begin
        // The slowest period is held for a full dwell interval before the generator is released.
        if (step_now) begin
          cnt_d = '0;
          if (period_q == cfg_start_q) begin
            state_d    = IDLE;
            period_d   = '0;
            gen_d      = 1'b0;
            busy_d     = 1'b0;
            at_speed_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            period_d = inc_next;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        period_d   = '0;
        gen_d      = 1'b0;
        busy_d     = 1'b0;
        at_speed_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cfg_start_q  <= '0;
      cfg_target_q <= '0;
      cfg_step_q   <= '0;
      cfg_dwell_q  <= '0;
      cnt_q        <= '0;
      gen_q        <= 1'b0;
      busy_q       <= 1'b0;
      at_speed_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cfg_start_q  <= cfg_start_d;
      cfg_target_q <= cfg_target_d;
      cfg_step_q   <= cfg_step_d;
      cfg_dwell_q  <= cfg_dwell_d;
      cnt_q        <= cnt_d;
      gen_q        <= gen_d;
      busy_q       <= busy_d;
      at_speed_q   <= at_speed_d;
      done_q       <= done_d;
    end
  end

  assign bus.period_out = period_q;
  assign bus.gen_enable = gen_q;
  assign bus.busy       = busy_q;
  assign bus.at_speed   = at_speed_q;
  assign bus.done       = done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Bench for freq_ramp_ctrl: directed ramps plus randomized profiles, each checked
// cycle by cycle against a period sequence computed from the ramp rules.
module tb_freq_ramp_ctrl;
  localparam int PW = 32;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  freq_ramp_ctrl_if #(.PW(PW), .DW(DW)) bus ();

  freq_ramp_ctrl #(.PW(PW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Active ramp profile as the bench sees it
  longint sp, tp, stp;
  int     dw;
  logic [PW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic scramble();
    bus.start_period  = $urandom;
    bus.target_period = $urandom;
    bus.step          = $urandom;
    bus.dwell         = DW'($urandom);
  endtask

  task automatic check_idle(input string tag);
    chk_w({tag, "_period"}, bus.period_out, '0);
    chk_b({tag, "_gen"}, bus.gen_enable, 1'b0);
    chk_b({tag, "_busy"}, bus.busy, 1'b0);
    chk_b({tag, "_at_speed"}, bus.at_speed, 1'b0);
  endtask

  task automatic check_busy(input string tag, input logic [PW-1:0] p, input logic spd);
    chk_w({tag, "_period"}, bus.period_out, p);
    chk_b({tag, "_gen"}, bus.gen_enable, 1'b1);
    chk_b({tag, "_busy"}, bus.busy, 1'b1);
    chk_b({tag, "_at_speed"}, bus.at_speed, spd);
    chk_b({tag, "_done"}, bus.done, 1'b0);
  endtask

  // Reference: each accel value is the previous minus step, floored at target.
  task automatic begin_ramp(input logic [PW-1:0] s, input logic [PW-1:0] t,
                            input logic [PW-1:0] st, input int d, input bit with_stop);
    longint p;
    bus.start_period  = s;
    bus.target_period = t;
    bus.step          = st;
    bus.dwell         = DW'(d);
    bus.start         = 1'b1;
    bus.stop          = with_stop;
    sp  = longint'(s);
    tp  = longint'(t);
    stp = (st == '0) ? 64'sd1 : longint'(st);
    dw  = d;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    scramble();
    exp_q.delete();
    p = sp;
    while (p > tp) begin
      exp_q.push_back(PW'(p));
      p = p - stp;
      if (p < tp) p = tp;
    end
  endtask

  task automatic run_accel(input int stop_idx, output logic [PW-1:0] last, output bit stopped);
    stopped = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == stop_idx) begin
        check_busy("accel_stop", exp_q[i], 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        last     = exp_q[i];
        stopped  = 1'b1;
        return;
      end
      for (int c = 0; c <= dw; c++) begin
        check_busy("accel", exp_q[i], 1'b0);
        if (c == 0) bus.start = ($urandom_range(0, 1) == 1);
        tick();
        bus.start = 1'b0;
      end
    end
    check_busy("run_entry", PW'(tp), 1'b1);
    last = PW'(tp);
  endtask

  task automatic stop_from_run(input bit also_start);
    for (int c = 0; c < 3; c++) begin
      check_busy("run_hold", PW'(tp), 1'b1);
      bus.start = (c == 1);
      tick();
      bus.start = 1'b0;
    end
    bus.stop  = 1'b1;
    bus.start = also_start;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic hold_decel(input longint p);
    for (int c = 0; c <= dw; c++) begin
      check_busy("decel", PW'(p), 1'b0);
      tick();
    end
  endtask

  // Reference: each decel value is the previous plus step, capped at start_period.
  task automatic run_decel(input logic [PW-1:0] from);
    longint p;
    p = longint'(from);
    while (p != sp) begin
      hold_decel(p);
      p = p + stp;
      if (p > sp) p = sp;
    end
    hold_decel(sp);
    chk_b("done_pulse", bus.done, 1'b1);
    check_idle("end");
    tick();
    chk_b("done_clear", bus.done, 1'b0);
    check_idle("after_end");
  endtask

  task automatic full_ramp(input logic [PW-1:0] s, input logic [PW-1:0] t, input logic [PW-1:0] st,
                           input int d, input int stop_idx, input bit start_stop);
    logic [PW-1:0] last;
    bit stopped;
    begin_ramp(s, t, st, d, start_stop);
    run_accel(stop_idx, last, stopped);
    if (!stopped) stop_from_run(1'b1);
    run_decel(last);
  endtask

  initial begin
    logic [PW-1:0] last;
    bit stopped;
    longint s, t, span;
    int sidx;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    scramble();
    #3;
    check_idle("reset");
    chk_b("reset_done", bus.done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    // Nominal profile: 100,80,60 then 40 at speed, decel back to 100
    full_ramp(32'd100, 32'd40, 32'd20, 2, -1, 1'b0);
    // Clamp onto a target that is not a step multiple
    full_ramp(32'd100, 32'd45, 32'd20, 0, -1, 1'b0);
    // Zero step behaves as one
    full_ramp(32'd100, 32'd95, 32'd0, 0, -1, 1'b0);
    // Target slower than start goes straight to speed
    full_ramp(32'd100, 32'd120, 32'd20, 1, -1, 1'b0);
    // Stop while accelerating at period 60
    full_ramp(32'd100, 32'd40, 32'd20, 2, 2, 1'b0);
    // start and stop together while idle: ramp still begins
    full_ramp(32'd100, 32'd40, 32'd20, 1, -1, 1'b1);

    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("idle_stop");
    chk_b("idle_stop_done", bus.done, 1'b0);

    // Near full-scale values and a step larger than the start period
    full_ramp(32'hFFFF_FFF0, 32'hFFFF_FF00, 32'h20, 1, -1, 1'b0);
    full_ramp(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, -1, 1'b0);
    full_ramp(32'h30, 32'h10, 32'h40, 1, -1, 1'b0);

    // Asynchronous abort while at speed
    begin_ramp(32'd100, 32'd40, 32'd20, 0, 1'b0);
    run_accel(-1, last, stopped);
    reset = 1'b1;
    #1;
    check_idle("abort");
    chk_b("abort_done", bus.done, 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle("abort_idle");
      chk_b("abort_idle_done", bus.done, 1'b0);
    end

    for (int n = 0; n < 8; n++) begin
      s    = longint'($urandom);
      span = longint'($urandom_range(0, 200));
      if ($urandom_range(0, 3) == 0) begin
        t = s + span;
        if (t > 64'sh0000_0000_FFFF_FFFF) t = 64'sh0000_0000_FFFF_FFFF;
      end else begin
        t = s - span;
        if (t < 0) t = 0;
      end
      sidx = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 8));
      full_ramp(PW'(s), PW'(t), PW'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                sidx, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
